// File: rtl/conv_window_dispatch.sv
// Command sequencer: loads KxK weights, walks the padded map window by window, issues each
// gathered vector to the engine and writes each returned scalar to out_base + window index.
module conv_window_dispatch #(
  parameter int DATA_WIDTH = 16,
  parameter int VEC        = 64,
  parameter int ADDR_W     = 16,
  parameter int DIM_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_W-1:0]         cmd_in_base,
  input  logic [ADDR_W-1:0]         cmd_w_base,
  input  logic [ADDR_W-1:0]         cmd_out_base,
  input  logic [DIM_W-1:0]          cmd_in_w,
  input  logic [DIM_W-1:0]          cmd_in_h,
  input  logic [3:0]                cmd_kernel,
  input  logic [3:0]                cmd_stride,
  input  logic [3:0]                cmd_pad,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic                      eng_valid,
  input  logic                      eng_ready,
  output logic [VEC*DATA_WIDTH-1:0] eng_act,
  output logic [VEC*DATA_WIDTH-1:0] eng_wgt,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [DATA_WIDTH-1:0]     res_data,
  output logic                      out_wr_en,
  output logic [ADDR_W-1:0]         out_wr_addr,
  output logic [DATA_WIDTH-1:0]     out_wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  localparam int PW = DIM_W + 2;

  typedef enum logic [2:0] {IDLE, LOAD_W, GATHER, ISSUE, WAIT_RES, FIN} state_t;
  state_t state;

  logic [ADDR_W-1:0]     in_base, w_base, out_base, out_idx;
  logic [DIM_W-1:0]      in_w, in_h;
  logic [3:0]            k, s, p, ky, kx;
  logic [6:0]            cnt, kk;
  logic [PW-1:0]         orow, ocol;
  logic                  pend_vld, pend_rd;
  logic [5:0]            pend_lane;
  logic [DATA_WIDTH-1:0] act_q [VEC];
  logic [DATA_WIDTH-1:0] wgt_q [VEC];

  logic [PW-1:0]     pp, pad_w, pad_h, py, px, c_pw, c_ph, ck, next_col, next_row;
  logic              inb, cmd_bad, col_fits, row_fits;
  logic [ADDR_W-1:0] gather_addr;

  assign kk       = 7'(k) * 7'(k);
  assign pp       = PW'(p);
  assign pad_w    = PW'(in_w) + PW'({p, 1'b0});
  assign pad_h    = PW'(in_h) + PW'({p, 1'b0});
  assign py       = orow + PW'(ky);
  assign px       = ocol + PW'(kx);
  assign inb      = (py >= pp) && (py < pp + PW'(in_h)) && (px >= pp) && (px < pp + PW'(in_w));
  assign gather_addr = in_base + ADDR_W'(py - pp) * ADDR_W'(in_w) + ADDR_W'(px - pp);
  assign next_col = ocol + PW'(s);
  assign next_row = orow + PW'(s);
  assign col_fits = (next_col + PW'(k)) <= pad_w;
  assign row_fits = (next_row + PW'(k)) <= pad_h;

  assign c_pw    = PW'(cmd_in_w) + PW'({cmd_pad, 1'b0});
  assign c_ph    = PW'(cmd_in_h) + PW'({cmd_pad, 1'b0});
  assign ck      = PW'(cmd_kernel);
  assign cmd_bad = (cmd_kernel == 4'd0) || (cmd_kernel > 4'd8) || (cmd_stride == 4'd0) ||
                   (ck > c_pw) || (ck > c_ph);

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign eng_valid = (state == ISSUE);
  assign res_ready = (state == WAIT_RES);

  // Reads are decoded from registered state; padded slots never touch the scratchpad.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    if (state == LOAD_W && cnt < kk) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = w_base + ADDR_W'(cnt);
    end else if (state == GATHER && cnt < kk && inb) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = gather_addr;
    end
  end

  for (genvar i = 0; i < VEC; i++) begin : g_lane
    assign eng_act[i*DATA_WIDTH +: DATA_WIDTH] = act_q[i];
    assign eng_wgt[i*DATA_WIDTH +: DATA_WIDTH] = wgt_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_base     <= '0;
      w_base      <= '0;
      out_base    <= '0;
      out_idx     <= '0;
      in_w        <= '0;
      in_h        <= '0;
      k           <= '0;
      s           <= '0;
      p           <= '0;
      ky          <= '0;
      kx          <= '0;
      cnt         <= '0;
      orow        <= '0;
      ocol        <= '0;
      pend_vld    <= 1'b0;
      pend_rd     <= 1'b0;
      pend_lane   <= '0;
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      for (int i = 0; i < VEC; i++) begin
        act_q[i] <= '0;
        wgt_q[i] <= '0;
      end
    end else begin
      out_wr_en <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pend_vld  <= 1'b0;
      // Read data for the slot handled last cycle lands now.
      if (pend_vld) begin
        if (state == LOAD_W) wgt_q[pend_lane] <= mem_rd_data;
        else                 act_q[pend_lane] <= pend_rd ? mem_rd_data : '0;
      end
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_bad) begin
              err <= 1'b1;
            end else begin
              in_base  <= cmd_in_base;
              w_base   <= cmd_w_base;
              out_base <= cmd_out_base;
              in_w     <= cmd_in_w;
              in_h     <= cmd_in_h;
              k        <= cmd_kernel;
              s        <= cmd_stride;
              p        <= cmd_pad;
              cnt      <= '0;
              ky       <= '0;
              kx       <= '0;
              orow     <= '0;
              ocol     <= '0;
              out_idx  <= '0;
              for (int i = 0; i < VEC; i++) begin
                act_q[i] <= '0;
                wgt_q[i] <= '0;
              end
              state <= LOAD_W;
            end
          end
        end
        LOAD_W: begin
          if (cnt < kk) begin
            pend_vld  <= 1'b1;
            pend_rd   <= 1'b1;
            pend_lane <= cnt[5:0];
            cnt       <= cnt + 7'd1;
          end else begin
            cnt   <= '0;
            state <= GATHER;
          end
        end
        GATHER: begin
          if (cnt < kk) begin
            pend_vld  <= 1'b1;
            pend_rd   <= inb;
            pend_lane <= cnt[5:0];
            cnt       <= cnt + 7'd1;
            if (kx == k - 4'd1) begin
              kx <= '0;
              ky <= ky + 4'd1;
            end else begin
              kx <= kx + 4'd1;
            end
          end else begin
            cnt   <= '0;
            kx    <= '0;
            ky    <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (eng_ready) state <= WAIT_RES;
        end
        WAIT_RES: begin
          if (res_valid) begin
            out_wr_en   <= 1'b1;
            out_wr_addr <= out_base + out_idx;
            out_wr_data <= res_data;
            out_idx     <= out_idx + 1'b1;
            if (col_fits) begin
              ocol  <= next_col;
              state <= GATHER;
            end else begin
              ocol <= '0;
              if (row_fits) begin
                orow  <= next_row;
                state <= GATHER;
              end else begin
                state <= FIN;
              end
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
